// File: rtl/sort_seq_ctrl_if.sv
// Handshake/data bundle between a sort requester and the sort_seq_ctrl sequencer.
// master drives the request side; slave is the sequencer.
interface sort_seq_ctrl_if #(
    parameter int N = 4
);
    logic             start;
    logic [4*N-1:0]   data_in;
    logic             busy;
    logic             done;
    logic [4*N-1:0]   data_out;
    logic [5:0]       swap_count;

    modport master (
        output start, data_in,
        input  busy, done, data_out, swap_count
    );

    modport slave (
        input  start, data_in,
        output busy, done, data_out, swap_count
    );
endinterface

// File: rtl/sort_seq_ctrl.sv
// Bubble-sort sequencer: one adjacent pair per cycle through a shared 4-bit comparator,
// shrinking pass bound, early exit on a swap-free pass, done pulse with registered result.
module cmp4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       greater,
    output logic       lesser,
    output logic       equal
);
    assign greater = (a > b);
    assign lesser  = (a < b);
    assign equal   = (a == b);
endmodule

module sort_seq_ctrl #(
    parameter int N       = 4,
    parameter bit DESCEND = 1'b0
) (
    input logic             clk,
    input logic             rst,
    sort_seq_ctrl_if.slave  bus
);
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 2);

    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

    state_t            state;
    logic [N-1:0][3:0] work;
    logic [N-1:0][3:0] work_n;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     idx_hi;
    logic [IW-1:0]     pass;
    logic [5:0]        swaps;
    logic [5:0]        swaps_n;
    logic              pass_swapped;
    logic              pass_swapped_n;
    logic              gt, lt, eq;
    logic              out_of_order;
    logic              last_pair;

    assign idx_hi = idx + 1'b1;

    cmp4 u_cmp (
        .a       (work[idx]),
        .b       (work[idx_hi]),
        .greater (gt),
        .lesser  (lt),
        .equal   (eq)
    );

    // Equal entries never swap, which keeps the sort stable.
    assign out_of_order   = !eq && (DESCEND ? lt : gt);
    assign swaps_n        = swaps + {5'd0, out_of_order};
    assign pass_swapped_n = pass_swapped | out_of_order;
    assign last_pair      = (idx == LAST - pass);

    always_comb begin
        work_n = work;
        if (out_of_order) begin
            work_n[idx]    = work[idx_hi];
            work_n[idx_hi] = work[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            work           <= '0;
            idx            <= '0;
            pass           <= '0;
            swaps          <= '0;
            pass_swapped   <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.data_out   <= '0;
            bus.swap_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        work         <= bus.data_in;
                        idx          <= '0;
                        pass         <= '0;
                        swaps        <= '0;
                        pass_swapped <= 1'b0;
                        bus.busy     <= 1'b1;
                        state        <= SORT;
                    end
                end
                SORT: begin
                    work         <= work_n;
                    swaps        <= swaps_n;
                    pass_swapped <= pass_swapped_n;
                    if (!last_pair) begin
                        idx <= idx_hi;
                    end else if (pass == LAST || !pass_swapped_n) begin
                        // Result includes this cycle's exchange, so take it from work_n.
                        bus.data_out   <= work_n;
                        bus.swap_count <= swaps_n;
                        bus.busy       <= 1'b0;
                        bus.done       <= 1'b1;
                        state          <= DONE;
                    end else begin
                        idx          <= '0;
                        pass         <= pass + 1'b1;
                        pass_swapped <= 1'b0;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Randomized and directed checks of sort_seq_ctrl (ascending and descending instances)
// against an inversion-count / counting-sort reference model.
module tb_sort_seq_ctrl;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sort_seq_ctrl_if #(.N(N)) bus0 ();
    sort_seq_ctrl_if #(.N(N)) bus1 ();

    sort_seq_ctrl #(.N(N), .DESCEND(1'b0)) dut_asc (.clk(clk), .rst(rst), .bus(bus0));
    sort_seq_ctrl #(.N(N), .DESCEND(1'b1)) dut_dsc (.clk(clk), .rst(rst), .bus(bus1));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic drive(input bit desc, input logic st, input logic [15:0] d);
        if (desc) begin bus1.start = st; bus1.data_in = d; end
        else      begin bus0.start = st; bus0.data_in = d; end
    endtask

    task automatic peek(input bit desc, output logic b, output logic dn,
                        output logic [15:0] q, output logic [5:0] s);
        if (desc) begin b = bus1.busy; dn = bus1.done; q = bus1.data_out; s = bus1.swap_count; end
        else      begin b = bus0.busy; dn = bus0.done; q = bus0.data_out; s = bus0.swap_count; end
    endtask

    // Swaps = strict inversions; passes = max count of out-of-place elements ahead of any
    // element, plus one confirming pass, capped at N-1; result by counting sort.
    task automatic model(input logic [15:0] d, input bit desc, output logic [15:0] srt,
                         output int swaps, output int k);
        int v[N];
        int lmax, l, passes, pos, val;
        lmax = 0; swaps = 0; k = 0; pos = 0; srt = '0;
        for (int i = 0; i < N; i++) v[i] = int'(d[4*i +: 4]);
        for (int j = 0; j < N; j++) begin
            l = 0;
            for (int i = 0; i < j; i++)
                if (desc ? (v[i] < v[j]) : (v[i] > v[j])) l++;
            swaps += l;
            if (l > lmax) lmax = l;
        end
        passes = (lmax + 1 < N - 1) ? lmax + 1 : N - 1;
        for (int p = 0; p < passes; p++) k += N - 1 - p;
        for (int t = 0; t < 16; t++) begin
            val = desc ? 15 - t : t;
            for (int i = 0; i < N; i++)
                if (v[i] == val) begin
                    srt[4*pos +: 4] = 4'(val);
                    pos++;
                end
        end
    endtask

    task automatic run(input string name, input bit desc, input logic [15:0] d,
                       input int extra1, input int extra2, input int rst_at);
        logic [15:0] srt, q, q_at;
        logic [5:0]  s, s_at;
        logic        b, dn;
        int sw, k, first_done, n_done, n_busy, overlap;
        first_done = 0; n_done = 0; n_busy = 0; overlap = 0; q_at = '0; s_at = '0;
        model(d, desc, srt, sw, k);
        @(negedge clk);
        drive(desc, 1'b1, d);
        for (int c = 1; c <= k + 3; c++) begin
            @(negedge clk);
            drive(desc, (c == extra1 || c == extra2), ~d);
            if (c == rst_at) begin
                rst = 1'b1;
                drive(desc, 1'b0, d);
                @(negedge clk);
                rst = 1'b0;
                peek(desc, b, dn, q, s);
                chk({name, ".rst_busy"}, 32'(b), 32'd0);
                chk({name, ".rst_done"}, 32'(dn), 32'd0);
                chk({name, ".rst_dout"}, 32'(q), 32'd0);
                chk({name, ".rst_swaps"}, 32'(s), 32'd0);
                return;
            end
            peek(desc, b, dn, q, s);
            if (b) n_busy++;
            if (b && dn) overlap++;
            if (dn) begin
                n_done++;
                if (first_done == 0) begin first_done = c; q_at = q; s_at = s; end
            end
        end
        drive(desc, 1'b0, d);
        chk({name, ".done_cyc"}, 32'(first_done), 32'(k + 1));
        chk({name, ".busy_cycles"}, 32'(n_busy), 32'(k));
        chk({name, ".done_count"}, 32'(n_done), 32'd1);
        chk({name, ".overlap"}, 32'(overlap), 32'd0);
        chk({name, ".dout"}, 32'(q_at), 32'(srt));
        chk({name, ".swaps"}, 32'(s_at), 32'(sw));
    endtask

    initial begin
        logic [15:0] d, q;
        logic [5:0]  s;
        logic        b, dn;
        drive(1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, '0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            peek(u[0], b, dn, q, s);
            chk("reset_busy", 32'(b), 32'd0);
            chk("reset_done", 32'(dn), 32'd0);
            chk("reset_dout", 32'(q), 32'd0);
            chk("reset_swaps", 32'(s), 32'd0);
        end
        rst = 1'b0;

        run("t1", 1'b0, 16'h0F39, 0, 0, 0);
        peek(1'b0, b, dn, q, s);
        chk("t1_held_dout", 32'(q), 32'h0000_F930);
        chk("t1_held_swaps", 32'(s), 32'd4);
        run("t2_sorted", 1'b0, 16'h4321, 0, 0, 0);
        run("t3_equal", 1'b0, 16'h5555, 0, 0, 0);
        run("t4_desc", 1'b1, 16'h0F39, 0, 0, 0);
        peek(1'b1, b, dn, q, s);
        chk("t4_held_dout", 32'(q), 32'h0000_039F);
        run("t5_ignore", 1'b0, 16'h0F39, 2, 7, 0);
        run("t6_rst", 1'b0, 16'h0F39, 0, 0, 3);
        run("t6_after", 1'b0, 16'h3412, 0, 0, 0);
        peek(1'b0, b, dn, q, s);
        chk("t6_held_dout", 32'(q), 32'h0000_4321);
        chk("t6_held_swaps", 32'(s), 32'd2);

        for (int i = 0; i < 40; i++) begin
            d = 16'($urandom);
            if (i % 3 == 0) d = d & 16'h3333;
            run($sformatf("rnd%0d", i), i[0], d, 0, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
